// File: rtl/microondas_pkg.sv
// Shared state encodings, M:SS time type and the 9:59 limit for the microwave controller.
package microondas_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] tens;
        logic [3:0] ones;
    } mmss_t;

    localparam logic [3:0] MAX_TENS = 4'd5;
    localparam logic [3:0] MAX_ONES = 4'd9;
    localparam logic [9:0] MAX_SECS = 10'd599;   // 9:59

    function automatic logic [9:0] mmss_to_sec(input mmss_t t);
        return 10'(t.min) * 10'd60 + 10'(t.tens) * 10'd10 + 10'(t.ones);
    endfunction

    function automatic mmss_t sec_to_mmss(input logic [9:0] s);
        logic [9:0] rem;
        mmss_t      r;
        rem    = s % 10'd60;
        r.min  = 4'(s / 10'd60);
        r.tens = 4'(rem / 10'd10);
        r.ones = 4'(rem % 10'd10);
        return r;
    endfunction

endpackage

// File: rtl/mmss_counter.sv
// BCD M:SS time register: clear, load ADD_SEC, saturating add of ADD_SEC, and 1 s decrement.
module mmss_counter
    import microondas_pkg::*;
#(
    parameter int ADD_SEC = 30
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  load,
    input  logic  add,
    input  logic  dec,
    output mmss_t value,
    output logic  at_one
);

    localparam logic [10:0] INC = (ADD_SEC > 599) ? 11'd599 : 11'(ADD_SEC);

    function automatic mmss_t sat_add(input mmss_t t);
        logic [10:0] sum;
        sum = 11'(mmss_to_sec(t)) + INC;
        if (sum > 11'(MAX_SECS))
            sum = 11'(MAX_SECS);
        return sec_to_mmss(sum[9:0]);
    endfunction

    // Borrow ripples ones -> tens -> minutes; never called at 0:00.
    function automatic mmss_t bcd_dec(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.ones != 4'd0) begin
            r.ones = t.ones - 4'd1;
        end else begin
            r.ones = MAX_ONES;
            if (t.tens != 4'd0) begin
                r.tens = t.tens - 4'd1;
            end else begin
                r.tens = MAX_TENS;
                r.min  = t.min - 4'd1;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (load)
            value <= sat_add('0);
        else if (add)
            value <= sat_add(value);
        else if (dec)
            value <= bcd_dec(value);
    end

    assign at_one = (value.min == 4'd0) && (value.tens == 4'd0) && (value.ones == 4'd1);

endmodule

// File: rtl/microondas_ctrl.sv
// Microwave oven controller: button/door FSM, done-beep timer and registered outputs.
module microondas_ctrl
    import microondas_pkg::*;
#(
    parameter int ADD_SEC    = 30,
    parameter int BEEP_TICKS = 3
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_add,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       door_open,
    output logic       magnetron_on,
    output logic       light_on,
    output logic       beep,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state_o
);

    localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    state_t        state, next_state;
    logic [BW-1:0] beep_cnt, beep_cnt_next;
    logic          cnt_clear, cnt_load, cnt_add, cnt_dec;
    logic          at_one;
    mmss_t         time_val;
    logic          start_ok;

    assign start_ok = btn_start && !door_open;

    mmss_counter #(
        .ADD_SEC(ADD_SEC)
    ) u_time (
        .clk   (clock_in),
        .rst   (reset),
        .clear (cnt_clear),
        .load  (cnt_load),
        .add   (cnt_add),
        .dec   (cnt_dec),
        .value (time_val),
        .at_one(at_one)
    );

    // Each branch walks door > stop > start > add > tick; the first event that applies wins.
    always_comb begin
        next_state    = state;
        beep_cnt_next = beep_cnt;
        cnt_clear     = 1'b0;
        cnt_load      = 1'b0;
        cnt_add       = 1'b0;
        cnt_dec       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    cnt_load   = 1'b1;
                    next_state = COOK;
                end else if (btn_add) begin
                    cnt_load   = 1'b1;
                    next_state = SET;
                end
            end
            SET: begin
                if (btn_stop) begin
                    cnt_clear  = 1'b1;
                    next_state = IDLE;
                end else if (start_ok) begin
                    next_state = COOK;
                end else if (btn_add) begin
                    cnt_add = 1'b1;
                end
            end
            COOK: begin
                if (door_open || btn_stop) begin
                    next_state = PAUSE;
                end else if (btn_add) begin
                    cnt_add = 1'b1;
                end else if (tick_1hz) begin
                    cnt_dec = 1'b1;
                    if (at_one) begin
                        next_state    = DONE;
                        beep_cnt_next = '0;
                    end
                end
            end
            PAUSE: begin
                if (btn_stop) begin
                    cnt_clear  = 1'b1;
                    next_state = IDLE;
                end else if (start_ok) begin
                    next_state = COOK;
                end
            end
            DONE: begin
                if (door_open || btn_stop) begin
                    next_state    = IDLE;
                    beep_cnt_next = '0;
                end else if (tick_1hz) begin
                    if (beep_cnt == BEEP_LAST) begin
                        next_state    = IDLE;
                        beep_cnt_next = '0;
                    end else begin
                        beep_cnt_next = beep_cnt + 1'b1;
                    end
                end
            end
            default: begin
                cnt_clear  = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are decoded from next_state so they change on the same edge as the state.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            beep_cnt     <= '0;
            magnetron_on <= 1'b0;
            light_on     <= 1'b0;
            beep         <= 1'b0;
        end else begin
            state        <= next_state;
            beep_cnt     <= beep_cnt_next;
            magnetron_on <= (next_state == COOK);
            beep         <= (next_state == DONE);
            light_on     <= (next_state == COOK) || (next_state == PAUSE) || door_open;
        end
    end

    assign min_bcd  = time_val.min;
    assign sec_tens = time_val.tens;
    assign sec_ones = time_val.ones;
    assign state_o  = state;

endmodule

// File: tb/tb_microondas_ctrl.sv
// Directed bench for microondas_ctrl: vector table plus multi-cycle sequences.
module tb_microondas_ctrl;

    logic       clock_in = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_add = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       door_open = 1'b0;
    logic       magnetron_on, light_on, beep;
    logic [3:0] min_bcd, sec_tens, sec_ones;
    logic [2:0] state_o;

    int total = 0;
    int bad = 0;

    microondas_ctrl #(
        .ADD_SEC   (30),
        .BEEP_TICKS(3)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .btn_add     (btn_add),
        .btn_start   (btn_start),
        .btn_stop    (btn_stop),
        .door_open   (door_open),
        .magnetron_on(magnetron_on),
        .light_on    (light_on),
        .beep        (beep),
        .min_bcd     (min_bcd),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .state_o     (state_o)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       add, start, stop, tick, door;
        logic [2:0] st;
        logic [11:0] tm;
        logic       mag, light, bp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] bcd_of(input int s);
        return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] st, input logic [11:0] tm,
                             input logic mag, input logic light, input logic bp);
        check(name, {13'd0, state_o, min_bcd, sec_tens, sec_ones, magnetron_on, light_on, beep},
              {13'd0, st, tm, mag, light, bp});
    endtask

    task automatic cycle(input logic a, input logic s, input logic p, input logic t, input logic d);
        btn_add = a; btn_start = s; btn_stop = p; tick_1hz = t; door_open = d;
        @(posedge clock_in);
        #1;
        btn_add = 1'b0; btn_start = 1'b0; btn_stop = 1'b0; tick_1hz = 1'b0;
        @(negedge clock_in);
    endtask

    initial begin
        // add start stop tick door | state time mag light beep
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b1, 3'd0, 12'h000, 1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd2, 12'h030, 1'b1,1'b1,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd2, 12'h100, 1'b1,1'b1,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0, 3'd2, 12'h130, 1'b1,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, 3'd2, 12'h129, 1'b1,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,1'b0,1'b0, 3'd3, 12'h129, 1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, 3'd3, 12'h129, 1'b0,1'b1,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd3, 12'h129, 1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 3'd0, 12'h000, 1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd2, 12'h030, 1'b1,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b0, 3'd2, 12'h029, 1'b1,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b0,1'b1, 3'd3, 12'h029, 1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1, 3'd3, 12'h029, 1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b1, 3'd3, 12'h029, 1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0, 3'd2, 12'h029, 1'b1,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 3'd3, 12'h029, 1'b0,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 3'd0, 12'h000, 1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1, 12'h030, 1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b0,1'b0, 3'd1, 12'h100, 1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b1,1'b0,1'b0, 3'd0, 12'h000, 1'b0,1'b0,1'b0});

        // Reset state
        #2;
        check_all("reset_async", 3'd0, 12'h000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clock_in);
        reset = 1'b0;
        @(negedge clock_in);
        check_all("reset_idle", 3'd0, 12'h000, 1'b0, 1'b0, 1'b0);

        // Vector table
        foreach (vecs[i]) begin
            cycle(vecs[i].add, vecs[i].start, vecs[i].stop, vecs[i].tick, vecs[i].door);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].tm, vecs[i].mag, vecs[i].light, vecs[i].bp);
        end

        // Two adds, start, 60 ticks to DONE, then 3 beep ticks
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("set_1_00", 3'd1, 12'h100, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("cook_1_00", 3'd2, 12'h100, 1'b1, 1'b1, 1'b0);
        for (int k = 59; k >= 1; k--) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("count_%0d", k), {17'd0, state_o, min_bcd, sec_tens, sec_ones},
                  {17'd0, 3'd2, bcd_of(k)});
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("done_0_00", 3'd4, 12'h000, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("done_hold", 3'd4, 12'h000, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("done_beep1", 3'd4, 12'h000, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("done_beep2", 3'd4, 12'h000, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("done_to_idle", 3'd0, 12'h000, 1'b0, 1'b0, 1'b0);

        // Door opened at 0:45 pauses and holds time
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (15) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("cook_0_45", 3'd2, 12'h045, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_all("door_pause", 3'd3, 12'h045, 1'b0, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_all("pause_ticks", 3'd3, 12'h045, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("resume_0_45", 3'd2, 12'h045, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_all("stop_idle", 3'd0, 12'h000, 1'b0, 1'b0, 1'b0);

        // Saturation at 9:59 in SET and in COOK
        repeat (19) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("set_9_30", 3'd1, 12'h930, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("set_sat1", 3'd1, 12'h959, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("set_sat2", 3'd1, 12'h959, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (14) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("cook_9_45", 3'd2, 12'h945, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("cook_sat", 3'd2, 12'h959, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Door opened in DONE returns straight to IDLE
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (30) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_all("done_quick", 3'd4, 12'h000, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_all("done_door", 3'd0, 12'h000, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("door_closed", 3'd0, 12'h000, 1'b0, 1'b0, 1'b0);

        // Reset between edges mid-COOK
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("pre_reset_cook", 3'd2, 12'h030, 1'b1, 1'b1, 1'b0);
        @(posedge clock_in);
        #3;
        reset = 1'b1;
        #1;
        check("reset_mag_now", {31'd0, magnetron_on}, 32'd0);
        check_all("reset_now", 3'd0, 12'h000, 1'b0, 1'b0, 1'b0);
        @(posedge clock_in);
        #2;
        reset = 1'b0;
        @(negedge clock_in);
        check_all("after_release", 3'd0, 12'h000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_all("first_edge_acts", 3'd2, 12'h030, 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
